// File: rtl/btn_event_decoder.sv
// btn_event_decoder
// Turns the debounced button level into single-cycle event strobes:
// short press, long press, auto-repeat while held and, when the
// BTN_DCLICK_EN macro is defined, double-click. Without BTN_DCLICK_EN the
// GAP/PRESS2 states are not built, o_double is tied low and o_short fires
// on the release edge. All event outputs and o_busy are registered.
module btn_event_decoder #(
  parameter int LONG_CNT   = 50_000_000,
  parameter int REPEAT_CNT = 10_000_000,
  parameter int DCLICK_CNT = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_short,
  output logic o_long,
  output logic o_repeat,
  output logic o_double,
  output logic o_busy
);

  // One shared counter, sized for the largest interval it has to reach.
  localparam int MAX_LR  = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
  localparam int MAX_CNT = (MAX_LR > DCLICK_CNT) ? MAX_LR : DCLICK_CNT;
  localparam int CW      = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;

  localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CNT - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CNT - 1);
`ifdef BTN_DCLICK_EN
  // The release edge itself is the first edge of the gap window, so the
  // gap expires when the counter (which starts on the next edge) reaches
  // DCLICK_CNT-2: o_short lands DCLICK_CNT-1 edges after the release edge.
  localparam logic [CW-1:0] GAP_LAST    = CW'(DCLICK_CNT - 2);
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS  = 3'd1,
    HOLD   = 3'd2
`ifdef BTN_DCLICK_EN
    ,
    GAP    = 3'd3,
    PRESS2 = 3'd4
`endif
  } state_e;

  state_e        state_r;
  logic [CW-1:0] cnt_r;
  logic          short_r;
  logic          long_r;
  logic          repeat_r;
  logic          busy_r;
`ifdef BTN_DCLICK_EN
  logic          double_r;
`endif

  // Gesture FSM: state, shared counter and all registered event strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= CNT_ZERO;
      short_r  <= 1'b0;
      long_r   <= 1'b0;
      repeat_r <= 1'b0;
      busy_r   <= 1'b0;
`ifdef BTN_DCLICK_EN
      double_r <= 1'b0;
`endif
    end else begin
      // Strobes default low; busy stays high unless a branch returns to IDLE.
      short_r  <= 1'b0;
      long_r   <= 1'b0;
      repeat_r <= 1'b0;
      busy_r   <= 1'b1;
`ifdef BTN_DCLICK_EN
      double_r <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          cnt_r <= CNT_ZERO;
          if (i_btn) begin
            state_r <= PRESS;
          end else begin
            busy_r <= 1'b0;
          end
        end

        PRESS: begin
          if (!i_btn) begin
            cnt_r <= CNT_ZERO;
`ifdef BTN_DCLICK_EN
            // Defer the verdict: a quick re-press may still make this a double.
            state_r <= GAP;
`else
            short_r <= 1'b1;
            state_r <= IDLE;
            busy_r  <= 1'b0;
`endif
          end else if (cnt_r == LONG_LAST) begin
            long_r  <= 1'b1;
            cnt_r   <= CNT_ZERO;
            state_r <= HOLD;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        HOLD: begin
          // Release wins over a repeat falling on the same edge.
          if (!i_btn) begin
            cnt_r   <= CNT_ZERO;
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (cnt_r == REPEAT_LAST) begin
            repeat_r <= 1'b1;
            cnt_r    <= CNT_ZERO;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

`ifdef BTN_DCLICK_EN
        GAP: begin
          if (i_btn) begin
            cnt_r   <= CNT_ZERO;
            state_r <= PRESS2;
          end else if (cnt_r == GAP_LAST) begin
            short_r <= 1'b1;
            cnt_r   <= CNT_ZERO;
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        PRESS2: begin
          // Second press is not timed; only its release matters.
          cnt_r <= CNT_ZERO;
          if (!i_btn) begin
            double_r <= 1'b1;
            state_r  <= IDLE;
            busy_r   <= 1'b0;
          end else begin
            state_r <= PRESS2;
          end
        end
`endif

        default: begin
          cnt_r   <= CNT_ZERO;
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_short  = short_r;
  assign o_long   = long_r;
  assign o_repeat = repeat_r;
  assign o_busy   = busy_r;
`ifdef BTN_DCLICK_EN
  assign o_double = double_r;
`else
  assign o_double = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_decoder.sv
// Testbench for btn_event_decoder (LONG_CNT=20, REPEAT_CNT=5, DCLICK_CNT=8).
// A timestamp-based gesture model predicts every output each cycle; directed
// gestures additionally pin event edges to hand-computed offsets.
module tb_btn_event_decoder;

  localparam int LONG_CNT   = 20;
  localparam int REPEAT_CNT = 5;
  localparam int DCLICK_CNT = 8;
`ifdef BTN_DCLICK_EN
  localparam int SHORT_LAT  = DCLICK_CNT - 1;
`else
  localparam int SHORT_LAT  = 0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic i_btn = 1'b0;
  logic o_short, o_long, o_repeat, o_double, o_busy;

  btn_event_decoder #(
    .LONG_CNT  (LONG_CNT),
    .REPEAT_CNT(REPEAT_CNT),
    .DCLICK_CNT(DCLICK_CNT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (i_btn),
    .o_short (o_short),
    .o_long  (o_long),
    .o_repeat(o_repeat),
    .o_double(o_double),
    .o_busy  (o_busy)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Edge index as seen from the following negedge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 button down (first press), 2 release gap, 3 second press
  // t0: edge index at which the current phase began; events follow from the
  // age of the phase in edges.
  int         m_phase = 0;
  int         m_t0    = 0;
  int         m_edge  = 0;
  logic [4:0] exp_v   = 5'b0;   // {short, long, repeat, double, busy}

  always @(posedge clk or posedge reset) begin : model
    int   ph, t0, n, age;
    logic s, l, rp, d;
    if (reset) begin
      m_phase <= 0;
      m_t0    <= 0;
      exp_v   <= 5'b0;
    end else begin
      n   = m_edge + 1;
      ph  = m_phase;
      t0  = m_t0;
      age = n - t0;
      s = 1'b0; l = 1'b0; rp = 1'b0; d = 1'b0;
      case (ph)
        0: if (i_btn) begin ph = 1; t0 = n; end
        1: begin
          if (!i_btn) begin
            if (age <= LONG_CNT) begin
`ifdef BTN_DCLICK_EN
              ph = 2; t0 = n;
`else
              s = 1'b1; ph = 0;
`endif
            end else begin
              ph = 0;
            end
          end else if (age == LONG_CNT) begin
            l = 1'b1;
          end else if (age > LONG_CNT && ((age - LONG_CNT) % REPEAT_CNT) == 0) begin
            rp = 1'b1;
          end
        end
        2: begin
          if (i_btn) ph = 3;
          else if (age == DCLICK_CNT - 1) begin s = 1'b1; ph = 0; end
        end
        3: if (!i_btn) begin d = 1'b1; ph = 0; end
        default: ph = 0;
      endcase
      m_edge  <= n;
      m_phase <= ph;
      m_t0    <= t0;
      exp_v   <= {s, l, rp, d, (ph != 0)};
    end
  end

  // ---------------- checking / monitoring ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int short_q[$];
  int long_q[$];
  int rep_q[$];
  int dbl_q[$];
  int last_busy_fall = -1;
  logic prev_busy = 1'b0;

  // Advance one cycle, compare all outputs against the model, log event edges.
  task automatic step();
    logic [4:0] act;
    @(negedge clk);
    act = {o_short, o_long, o_repeat, o_double, o_busy};
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL cycle_compare edge=%0d got {short,long,rep,dbl,busy}=%b expected %b",
               cyc, act, exp_v);
    end
    n_checks++;
    if ($countones(act[4:1]) > 1) begin
      n_fail++;
      $display("FAIL one_event edge=%0d got events=%b expected at most one high", cyc, act[4:1]);
    end
    if (o_short)  short_q.push_back(cyc);
    if (o_long)   long_q.push_back(cyc);
    if (o_repeat) rep_q.push_back(cyc);
    if (o_double) dbl_q.push_back(cyc);
    if (prev_busy && !o_busy) last_busy_fall = cyc;
    prev_busy = o_busy;
  endtask

  task automatic hold(input logic v, input int n);
    i_btn = v;
    repeat (n) step();
  endtask

  task automatic dcheck(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int s, s2, sn, ln, rn, dn;

    // Reset
    repeat (3) step();
    reset = 1'b0;
    step();
    dcheck("reset_outputs", int'({o_short, o_long, o_repeat, o_double, o_busy}), 0);

    // Short press of 10 cycles
    s = cyc + 1; sn = short_q.size(); ln = long_q.size(); rn = rep_q.size();
    hold(1'b1, 10); hold(1'b0, 12);
    dcheck("t1_short_count", short_q.size() - sn, 1);
    dcheck("t1_short_edge", short_q[sn], s + 10 + SHORT_LAT);
    dcheck("t1_long_count", long_q.size() - ln, 0);
    dcheck("t1_repeat_count", rep_q.size() - rn, 0);
    dcheck("t1_busy_fall", last_busy_fall, s + 10 + SHORT_LAT);

    // Hold 32 cycles: long at 20, repeats at 25 and 30
    s = cyc + 1; sn = short_q.size(); ln = long_q.size(); rn = rep_q.size();
    hold(1'b1, 32); hold(1'b0, 12);
    dcheck("t2_long_count", long_q.size() - ln, 1);
    dcheck("t2_long_edge", long_q[ln], s + 20);
    dcheck("t2_repeat_count", rep_q.size() - rn, 2);
    dcheck("t2_repeat0_edge", rep_q[rn], s + 25);
    dcheck("t2_repeat1_edge", rep_q[rn + 1], s + 30);
    dcheck("t2_short_count", short_q.size() - sn, 0);
    dcheck("t2_busy_fall", last_busy_fall, s + 32);

    // Boundary: release sampled at edge 19 is short
    s = cyc + 1; sn = short_q.size(); ln = long_q.size();
    hold(1'b1, 19); hold(1'b0, 12);
    dcheck("t3a_short_count", short_q.size() - sn, 1);
    dcheck("t3a_short_edge", short_q[sn], s + 19 + SHORT_LAT);
    dcheck("t3a_long_count", long_q.size() - ln, 0);

    // Boundary: still pressed at edge 20 is long only
    s = cyc + 1; sn = short_q.size(); ln = long_q.size();
    hold(1'b1, 21); hold(1'b0, 12);
    dcheck("t3b_long_count", long_q.size() - ln, 1);
    dcheck("t3b_long_edge", long_q[ln], s + 20);
    dcheck("t3b_short_count", short_q.size() - sn, 0);

`ifdef BTN_DCLICK_EN
    // Double-click: press 5, gap 3, press 5
    s = cyc + 1; sn = short_q.size(); dn = dbl_q.size();
    hold(1'b1, 5); hold(1'b0, 3); hold(1'b1, 5); hold(1'b0, 12);
    dcheck("d1_double_count", dbl_q.size() - dn, 1);
    dcheck("d1_double_edge", dbl_q[dn], s + 13);
    dcheck("d1_short_count", short_q.size() - sn, 0);

    // Gap of 8: first press expires as short, second press is a new gesture
    s = cyc + 1; sn = short_q.size(); dn = dbl_q.size();
    hold(1'b1, 5); hold(1'b0, 8); hold(1'b1, 5); hold(1'b0, 12);
    dcheck("d2_short_count", short_q.size() - sn, 2);
    dcheck("d2_short0_edge", short_q[sn], s + 12);
    dcheck("d2_short1_edge", short_q[sn + 1], s + 25);
    dcheck("d2_double_count", dbl_q.size() - dn, 0);
`endif

    // Reset mid-HOLD with the button held, then long press re-timed
    hold(1'b1, 23);
    #2 reset = 1'b1;
    #1;
    dcheck("rst_outputs", int'({o_short, o_long, o_repeat, o_double}), 0);
    dcheck("rst_busy", int'(o_busy), 0);
    step(); step();
    reset = 1'b0;
    s2 = cyc + 1; ln = long_q.size();
    hold(1'b1, 25); hold(1'b0, 12);
    dcheck("rst_long_count", long_q.size() - ln, 1);
    dcheck("rst_long_edge", long_q[ln], s2 + 20);

    // Randomized gestures, checked every cycle against the model
    for (int i = 0; i < 40; i++) begin
      hold(1'b1, $urandom_range(1, 40));
      hold(1'b0, $urandom_range(1, 14));
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 1) i_btn = 1'b1;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
      end
    end
    hold(1'b0, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
